microwave_timer_ctrl: RTL and testbench

Countdown timer controller that owns the three BCD digits (min, sec_tens, sec_ones) feeding the 7-segment decoder in the microwave design. It takes keypad digit entry, start/stop/clear commands and the door sensor. It counts the time down once per second, drives the magnetron enable, and pulses done at 0:00. Outputs connect directly to the decoder's min/sec_tens/sec_ones inputs.

---
 rtl/microwave_timer_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_microwave_timer_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_timer_ctrl.sv
// Microwave countdown timer: keypad BCD entry, start/stop/clear, door interlock, 1 Hz countdown.
// Define ADD30_EN to make start add 30 s while cooking and load 0:30 from an empty display.
module microwave_timer_ctrl #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       door_closed,
    output logic [3:0] min,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       mag_on,
    output logic       done
);

    localparam int              PW      = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0]   PS_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        IDLE,
        COOK,
        PAUSED
    } state_t;

    state_t        state;
    logic [PW-1:0] prescaler;

    logic       time_zero;
    logic       key_ok;
    logic       hold_req;
    logic       tick;
    logic       add_now;

    logic [3:0] dec_min;
    logic [3:0] dec_tens;
    logic [3:0] dec_ones;
    logic       dec_zero;

    logic [3:0] add_min;
    logic [3:0] add_tens;
    logic [3:0] add_ones;
    logic [3:0] tens_sum;

    assign time_zero = (min == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
    // A shift is only legal when the digit moving into sec_tens is still 0..5.
    assign key_ok    = key_valid && (key_digit <= 4'd9) && (sec_ones <= 4'd5);
    assign hold_req  = stop || !door_closed;
    assign tick      = (prescaler == PS_LAST);

`ifdef ADD30_EN
    assign add_now = start;
`else
    assign add_now = 1'b0;
`endif

    // BCD borrow chain for the one-second decrement; seconds tens wrap to 5.
    always_comb begin
        dec_min  = min;
        dec_tens = sec_tens;
        dec_ones = sec_ones;
        if (sec_ones != 4'd0) begin
            dec_ones = sec_ones - 4'd1;
        end else begin
            dec_ones = 4'd9;
            if (sec_tens != 4'd0) begin
                dec_tens = sec_tens - 4'd1;
            end else begin
                dec_tens = 4'd5;
                dec_min  = min - 4'd1;
            end
        end
    end

    assign dec_zero = (min == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1);

    // +30 s: base-6 carry out of the tens digit, saturate at 9:59 on minute overflow.
    always_comb begin
        tens_sum = sec_tens + 4'd3;
        add_min  = min;
        add_tens = tens_sum;
        add_ones = sec_ones;
        if (tens_sum >= 4'd6) begin
            add_tens = tens_sum - 4'd6;
            if (min == 4'd9) begin
                add_min  = 4'd9;
                add_tens = 4'd5;
                add_ones = 4'd9;
            end else begin
                add_min = min + 4'd1;
            end
        end
    end

    // NOTE: every register, outputs included, is updated with non-blocking
    // assignments in this single block so all next-state terms see pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            min       <= 4'd0;
            sec_tens  <= 4'd0;
            sec_ones  <= 4'd0;
            prescaler <= '0;
            mag_on    <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        min       <= 4'd0;
                        sec_tens  <= 4'd0;
                        sec_ones  <= 4'd0;
                        prescaler <= '0;
                    end else if (!hold_req) begin
                        if (start) begin
                            if (!time_zero) begin
                                state     <= COOK;
                                mag_on    <= 1'b1;
                                prescaler <= '0;
                            end else if (add_now) begin
                                sec_tens  <= 4'd3;
                                state     <= COOK;
                                mag_on    <= 1'b1;
                                prescaler <= '0;
                            end
                        end else if (key_ok) begin
                            min      <= sec_tens;
                            sec_tens <= sec_ones;
                            sec_ones <= key_digit;
                        end
                    end
                end

                COOK: begin
                    if (clear) begin
                        state     <= IDLE;
                        mag_on    <= 1'b0;
                        min       <= 4'd0;
                        sec_tens  <= 4'd0;
                        sec_ones  <= 4'd0;
                        prescaler <= '0;
                    end else if (hold_req) begin
                        state  <= PAUSED;
                        mag_on <= 1'b0;
                    end else begin
                        prescaler <= tick ? '0 : prescaler + PW'(1);
                        // A start that lands on the wrap cycle wins; that second's decrement is dropped.
                        if (add_now) begin
                            min      <= add_min;
                            sec_tens <= add_tens;
                            sec_ones <= add_ones;
                        end else if (tick) begin
                            min      <= dec_min;
                            sec_tens <= dec_tens;
                            sec_ones <= dec_ones;
                            if (dec_zero) begin
                                state  <= IDLE;
                                mag_on <= 1'b0;
                                done   <= 1'b1;
                            end
                        end
                    end
                end

                PAUSED: begin
                    if (clear) begin
                        state     <= IDLE;
                        min       <= 4'd0;
                        sec_tens  <= 4'd0;
                        sec_ones  <= 4'd0;
                        prescaler <= '0;
                    end else if (!hold_req && start) begin
                        state  <= COOK;
                        mag_on <= 1'b1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    mag_on <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Scoreboard bench for microwave_timer_ctrl with TICKS_PER_SEC = 4.
// Stimulus queues the expected display/magnetron/done state for a future edge; a monitor checks it.
module tb_microwave_timer_ctrl;

    localparam int TPS = 4;

    logic       clock;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       start;
    logic       stop;
    logic       clear;
    logic       door_closed;
    logic [3:0] min;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       mag_on;
    logic       done;

    microwave_timer_ctrl #(.TICKS_PER_SEC(TPS)) dut (
        .clock       (clock),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .door_closed (door_closed),
        .min         (min),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .mag_on      (mag_on),
        .done        (done)
    );

    typedef struct {
        int         at;
        logic [3:0] m;
        logic [3:0] t;
        logic [3:0] o;
        logic       mg;
        logic       dn;
        int         dcnt;
        string      name;
    } exp_t;

    exp_t q[$];
    int   edges      = 0;
    int   seen_dones = 0;
    int   want_dones = 0;
    int   tests      = 0;
    int   fails      = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) edges++;

    // Monitor: count done pulses, then check every expectation due at this edge.
    always @(negedge clock) begin
        if (done === 1'b1) seen_dones++;
        while (q.size() > 0 && q[0].at <= edges) begin
            check(q.pop_front());
        end
    end

    task automatic check(input exp_t e);
        tests++;
        if ({min, sec_tens, sec_ones, mag_on, done} !== {e.m, e.t, e.o, e.mg, e.dn} ||
            seen_dones != e.dcnt) begin
            fails++;
            $display("FAIL %s: got %0h:%0h%0h mag=%b done=%b dones=%0d, want %0h:%0h%0h mag=%b done=%b dones=%0d",
                     e.name, min, sec_tens, sec_ones, mag_on, done, seen_dones,
                     e.m, e.t, e.o, e.mg, e.dn, e.dcnt);
        end
    endtask

    task automatic expect_at(input int k, input logic [3:0] m, input logic [3:0] t,
                             input logic [3:0] o, input logic mg, input logic dn,
                             input string nm);
        exp_t e;
        e.at   = edges + k;
        e.m    = m;
        e.t    = t;
        e.o    = o;
        e.mg   = mg;
        e.dn   = dn;
        e.dcnt = want_dones;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic cmd(input logic s, input logic sp, input logic cl, input logic kv,
                       input logic [3:0] kd);
        start     = s;
        stop      = sp;
        clear     = cl;
        key_valid = kv;
        key_digit = kd;
        @(negedge clock);
        start     = 1'b0;
        stop      = 1'b0;
        clear     = 1'b0;
        key_valid = 1'b0;
        key_digit = 4'd0;
    endtask

    task automatic press(input logic [3:0] d);
        cmd(1'b0, 1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic go();
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic do_clear();
        cmd(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        key_valid   = 1'b0;
        key_digit   = 4'd0;
        start       = 1'b0;
        stop        = 1'b0;
        clear       = 1'b0;
        door_closed = 1'b1;
        @(negedge clock);
        expect_at(1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "reset");
        @(negedge clock);
        reset = 1'b0;

        // Key entry 1,3,0 and start; first decrement exactly TPS edges later.
        expect_at(1, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0, "key1");
        press(4'd1);
        expect_at(1, 4'd0, 4'd1, 4'd3, 1'b0, 1'b0, "key3");
        press(4'd3);
        expect_at(1, 4'd1, 4'd3, 4'd0, 1'b0, 1'b0, "key0");
        press(4'd0);
        expect_at(1, 4'd1, 4'd3, 4'd0, 1'b1, 1'b0, "start_130");
        go();
        expect_at(3, 4'd1, 4'd3, 4'd0, 1'b1, 1'b0, "pre_tick");
        expect_at(4, 4'd1, 4'd2, 4'd9, 1'b1, 1'b0, "tick_129");
        repeat (4) @(negedge clock);
        expect_at(1, 4'd1, 4'd2, 4'd9, 1'b0, 1'b0, "stop_pause");
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        expect_at(1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "clear_paused");
        do_clear();

        // Borrow from minutes, borrow from tens, countdown to done.
        press(4'd1);
        press(4'd0);
        press(4'd0);
        expect_at(1, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0, "start_100");
        go();
        expect_at(4, 4'd0, 4'd5, 4'd9, 1'b1, 1'b0, "borrow_min");
        repeat (4) @(negedge clock);
        do_clear();
        press(4'd5);
        press(4'd0);
        expect_at(1, 4'd0, 4'd5, 4'd0, 1'b1, 1'b0, "start_050");
        go();
        expect_at(4, 4'd0, 4'd4, 4'd9, 1'b1, 1'b0, "borrow_tens");
        repeat (4) @(negedge clock);
        do_clear();
        press(4'd1);
        expect_at(1, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0, "start_001");
        go();
        want_dones = 1;
        expect_at(4, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, "done_pulse");
        expect_at(5, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "done_one_cycle");
        repeat (5) @(negedge clock);

        // Key rejection rules and start at 0:00.
        expect_at(1, 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, "key7");
        press(4'd7);
        expect_at(1, 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, "reject_8_after_7");
        press(4'd8);
        do_clear();
        expect_at(1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "reject_a");
        press(4'hA);
`ifdef ADD30_EN
        expect_at(1, 4'd0, 4'd3, 4'd0, 1'b1, 1'b0, "add30_from_zero");
        go();
        do_clear();
`else
        expect_at(1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "start_zero");
        expect_at(2, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "start_zero_hold");
        go();
        @(negedge clock);
`endif

        // Door opened on the tick cycle pauses without decrementing; resume keeps prescaler.
        press(4'd4);
        press(4'd5);
        expect_at(1, 4'd0, 4'd4, 4'd5, 1'b1, 1'b0, "start_045");
        go();
        repeat (3) @(negedge clock);
        door_closed = 1'b0;
        expect_at(1, 4'd0, 4'd4, 4'd5, 1'b0, 1'b0, "door_pause");
        expect_at(3, 4'd0, 4'd4, 4'd5, 1'b0, 1'b0, "paused_hold");
        repeat (3) @(negedge clock);
        door_closed = 1'b1;
        expect_at(1, 4'd0, 4'd4, 4'd5, 1'b1, 1'b0, "resume");
        expect_at(2, 4'd0, 4'd4, 4'd4, 1'b1, 1'b0, "resume_tick");
        go();
        @(negedge clock);
        expect_at(1, 4'd0, 4'd4, 4'd4, 1'b0, 1'b0, "stop_044");
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        expect_at(1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "clear_no_done");
        do_clear();

        // Clear beats everything; reset mid-cook.
        press(4'd2);
        press(4'd0);
        go();
        @(negedge clock);
        expect_at(1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "clear_wins");
        cmd(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
        press(4'd2);
        press(4'd0);
        expect_at(1, 4'd0, 4'd2, 4'd0, 1'b1, 1'b0, "start_020");
        go();
        @(negedge clock);
        reset = 1'b1;
        expect_at(1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "reset_midcook");
        @(negedge clock);
        reset = 1'b0;
        expect_at(1, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, "key_after_reset");
        press(4'd3);
        do_clear();

`ifdef ADD30_EN
        // 5:45 plus repeated +30 s, keeping clear of tick edges, ends saturated at 9:59.
        press(4'd5);
        press(4'd4);
        press(4'd5);
        expect_at(1, 4'd5, 4'd4, 4'd5, 1'b1, 1'b0, "start_545");
        go();
        repeat (3) go();
        @(negedge clock);
        repeat (3) go();
        @(negedge clock);
        expect_at(2, 4'd9, 4'd4, 4'd3, 1'b1, 1'b0, "add30_pre_sat");
        expect_at(3, 4'd9, 4'd5, 4'd9, 1'b1, 1'b0, "add30_sat");
        repeat (3) go();
        do_clear();
        press(4'd4);
        press(4'd0);
        go();
        expect_at(1, 4'd1, 4'd1, 4'd0, 1'b1, 1'b0, "add30_carry");
        go();
        do_clear();
`endif

        repeat (3) @(negedge clock);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            tests++;
            fails++;
            $display("FAIL %s: never checked, was due at edge %0d, now edge %0d", e.name, e.at, edges);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
